lsu_mem_stage: RTL

Load/store unit for the pipeline MEM stage. Sits directly upstream of the data memory system (cache controller + cache + backing memory). Converts byte-addressed RV32I loads/stores from the EX/MEM register into word-granular requests, holds them until the memory system stops stalling, and returns aligned, sign/zero-extended load data. Sub-word stores are done as read-modify-write, because the memory system only writes whole 32-bit words.

---
 rtl/lsu_mem_stage_if.sv | 39 +++
 rtl/lsu_mem_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_stage_if
//  Purpose  : Pipeline-side and memory-side signal bundle for lsu_mem_stage.
//             master = the LSU itself, slave = pipeline/memory environment.
//  Revision : 1.0  initial release
// ============================================================================
interface lsu_mem_stage_if;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [11:0] byte_addr;
    logic [31:0] store_data;
    logic        pipe_stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        addr_fault;
    logic        mem_read;
    logic        mem_write;
    logic [9:0]  word_address;
    logic [31:0] mem_data_in;
    logic        mem_stall;
    logic [31:0] mem_data_out;

    modport master (
        input  req_valid, req_write, funct3, byte_addr, store_data,
        input  mem_stall, mem_data_out,
        output pipe_stall, load_data, load_valid, addr_fault,
        output mem_read, mem_write, word_address, mem_data_in
    );

    modport slave (
        output req_valid, req_write, funct3, byte_addr, store_data,
        output mem_stall, mem_data_out,
        input  pipe_stall, load_data, load_valid, addr_fault,
        input  mem_read, mem_write, word_address, mem_data_in
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_stage
//  Purpose  : MEM-stage load/store unit; word-granular memory requests with
//             read-modify-write for sub-word stores. Macro: LSU_SUBWORD_EN.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_mem_stage (
    input  wire             clk,
    input  wire             rst,     // asynchronous, active low
    lsu_mem_stage_if.master bus
);
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ACCESS = 3'd1;
`ifdef LSU_SUBWORD_EN
    localparam logic [2:0] c_ST_RMW_RD = 3'd2;
    localparam logic [2:0] c_ST_RMW_WR = 3'd3;
`endif
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic        r_write;
    logic        r_fault;
    logic [9:0]  r_word_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_load_data;
    logic        w_legal;
    logic [31:0] w_load_ext;

`ifdef LSU_SUBWORD_EN
    logic [1:0]  r_byte_off;
    logic [2:0]  r_funct3;
    logic        w_rmw;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_merged;

    always_comb begin
        w_legal = 1'b0;
        case (bus.funct3)
            3'b000, 3'b100: w_legal = 1'b1;
            3'b001, 3'b101: w_legal = ~bus.byte_addr[0];
            3'b010:         w_legal = (bus.byte_addr[1:0] == 2'b00);
            default:        w_legal = 1'b0;
        endcase
    end

    // Any store narrower than a word needs the old word first
    assign w_rmw = bus.req_write & (bus.funct3[1:0] != 2'b10);

    always_comb begin
        w_lane_b = bus.mem_data_out[7:0];
        case (r_byte_off)
            2'd0: w_lane_b = bus.mem_data_out[7:0];
            2'd1: w_lane_b = bus.mem_data_out[15:8];
            2'd2: w_lane_b = bus.mem_data_out[23:16];
            2'd3: w_lane_b = bus.mem_data_out[31:24];
            default: w_lane_b = bus.mem_data_out[7:0];
        endcase
        w_lane_h = r_byte_off[1] ? bus.mem_data_out[31:16] : bus.mem_data_out[15:0];
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_lane_b[7]}}, w_lane_b};
            3'b100:  w_load_ext = {24'h000000, w_lane_b};
            3'b001:  w_load_ext = {{16{w_lane_h[15]}}, w_lane_h};
            3'b101:  w_load_ext = {16'h0000, w_lane_h};
            default: w_load_ext = bus.mem_data_out;
        endcase
    end

    // r_wdata still holds the LSB-aligned store operand during RMW_RD
    always_comb begin
        w_merged = bus.mem_data_out;
        if (r_funct3[0]) begin
            if (r_byte_off[1]) w_merged[31:16] = r_wdata[15:0];
            else               w_merged[15:0]  = r_wdata[15:0];
        end else begin
            case (r_byte_off)
                2'd0: w_merged[7:0]   = r_wdata[7:0];
                2'd1: w_merged[15:8]  = r_wdata[7:0];
                2'd2: w_merged[23:16] = r_wdata[7:0];
                2'd3: w_merged[31:24] = r_wdata[7:0];
                default: w_merged = bus.mem_data_out;
            endcase
        end
    end
`else
    assign w_legal    = (bus.funct3 == 3'b010) & (bus.byte_addr[1:0] == 2'b00);
    assign w_load_ext = bus.mem_data_out;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.req_valid) begin
                    if (!w_legal)
                        w_next_state = c_ST_DONE;
`ifdef LSU_SUBWORD_EN
                    else if (w_rmw)
                        w_next_state = c_ST_RMW_RD;
`endif
                    else
                        w_next_state = c_ST_ACCESS;
                end
            end
            c_ST_ACCESS: if (!bus.mem_stall) w_next_state = c_ST_DONE;
`ifdef LSU_SUBWORD_EN
            c_ST_RMW_RD: if (!bus.mem_stall) w_next_state = c_ST_RMW_WR;
            c_ST_RMW_WR: if (!bus.mem_stall) w_next_state = c_ST_DONE;
`endif
            c_ST_DONE:   w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        bus.pipe_stall = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.load_valid = 1'b0;
        bus.addr_fault = 1'b0;
        case (r_state)
            c_ST_IDLE:   bus.pipe_stall = bus.req_valid;
            c_ST_ACCESS: begin
                bus.pipe_stall = 1'b1;
                bus.mem_read   = ~r_write;
                bus.mem_write  = r_write;
            end
`ifdef LSU_SUBWORD_EN
            c_ST_RMW_RD: begin
                bus.pipe_stall = 1'b1;
                bus.mem_read   = 1'b1;
            end
            c_ST_RMW_WR: begin
                bus.pipe_stall = 1'b1;
                bus.mem_write  = 1'b1;
            end
`endif
            c_ST_DONE: begin
                bus.load_valid = ~r_write & ~r_fault;
                bus.addr_fault = r_fault;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write     <= 1'b0;
            r_fault     <= 1'b0;
            r_word_addr <= 10'd0;
            r_wdata     <= 32'd0;
            r_load_data <= 32'd0;
`ifdef LSU_SUBWORD_EN
            r_byte_off  <= 2'd0;
            r_funct3    <= 3'd0;
`endif
        end else begin
            if (r_state == c_ST_IDLE && bus.req_valid) begin
                r_write     <= bus.req_write;
                r_fault     <= ~w_legal;
                r_word_addr <= bus.byte_addr[11:2];
                r_wdata     <= bus.store_data;
`ifdef LSU_SUBWORD_EN
                r_byte_off  <= bus.byte_addr[1:0];
                r_funct3    <= bus.funct3;
`endif
            end
            if (r_state == c_ST_ACCESS && !bus.mem_stall && !r_write)
                r_load_data <= w_load_ext;
`ifdef LSU_SUBWORD_EN
            if (r_state == c_ST_RMW_RD && !bus.mem_stall)
                r_wdata <= w_merged;
`endif
        end
    end

    assign bus.load_data    = r_load_data;
    assign bus.word_address = r_word_addr;
    assign bus.mem_data_in  = r_wdata;

endmodule
`default_nettype wire
